// File: rtl/bus_cycle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_pkg
// Description : Shared types and constants for the bus-cycle terminator.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_cycle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    FINISH = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam logic [1:0] PORT_EXT = 2'b00;
  localparam logic [1:0] PORT_8   = 2'b01;
  localparam logic [1:0] PORT_16  = 2'b10;
  localparam logic [1:0] PORT_32  = 2'b11;

  localparam int WDOG_W = 8;
  localparam int BOOT_W = 4;

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : bus_watchdog
// Description : Bus-error timeout counter, advanced on CPU_CLK ticks while /AS is low.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_watchdog
  import bus_cycle_pkg::*;
#(
  parameter int BERR_CYCLES = 64
) (
  input  logic DRAM_CLK,
  input  logic nRST,
  input  logic tick_i,
  input  logic nAS_i,
  output logic timeout_o
);

  localparam logic [WDOG_W-1:0] C_TERM = WDOG_W'(BERR_CYCLES - 1);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick_i) begin
      if (nAS_i) begin
        cnt_d = '0;
      end else if (cnt_q != C_TERM) begin
        cnt_d = cnt_q + WDOG_W'(1);
      end
    end
  end

  always_ff @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (cnt_q == C_TERM);

endmodule
`default_nettype wire

// File: rtl/bus_cycle_ctl.sv
`default_nettype none
// ============================================================================
// Module      : bus_cycle_ctl
// Description : N-channel 68030 bus-cycle terminator with BERR watchdog and boot overlay.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_cycle_ctl
  import bus_cycle_pkg::*;
#(
  parameter int NCHAN       = 4,
  parameter int WAIT_W      = 4,
  parameter int BERR_CYCLES = 64,
  parameter int BOOT_CYCLES = 4
) (
  input  logic                    DRAM_CLK,
  input  logic                    nRST,
  input  logic                    nAS,
  input  logic                    nDS,
  input  logic [NCHAN-1:0]        nSEL,
  input  logic [NCHAN*WAIT_W-1:0] CHAN_WAITS,
  input  logic [2*NCHAN-1:0]      CHAN_PORT,
  output logic                    CPU_CLK,
  output logic [1:0]              DSACK,
  output logic                    BERR,
  output logic                    BOOT,
  output logic                    BUSY
);

  localparam logic [BOOT_W-1:0] C_BOOT_END = BOOT_W'(BOOT_CYCLES);

  logic              cpu_clk_q;
  logic              tick;
  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [1:0]        port_q, port_d;
  logic [1:0]        dsack_q, dsack_d;
  logic              conflict_q, conflict_d;
  logic              nas_q;
  logic [BOOT_W-1:0] boot_q, boot_d;
  logic              timeout;

  logic [1:0]        port_arr  [NCHAN];
  logic [WAIT_W-1:0] waits_arr [NCHAN];
  logic [3:0]        sel_num;
  logic [1:0]        sel_port;
  logic [WAIT_W-1:0] sel_waits;

  // A tick is the DRAM_CLK edge on which CPU_CLK rises.
  assign tick = ~cpu_clk_q;

  generate
    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
      assign port_arr[g]  = CHAN_PORT[2*g +: 2];
      assign waits_arr[g] = CHAN_WAITS[g*WAIT_W +: WAIT_W];
    end
  endgenerate

  always_comb begin
    sel_num   = '0;
    sel_port  = PORT_EXT;
    sel_waits = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (!nSEL[i]) begin
        sel_num   = sel_num + 4'd1;
        sel_port  = port_arr[i];
        sel_waits = waits_arr[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    port_d     = port_q;
    dsack_d    = dsack_q;
    conflict_d = conflict_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!nAS) begin
            if (sel_num >= 4'd2) begin
              conflict_d = 1'b1;
              state_d    = HOLD;
            end else if (sel_num == 4'd1) begin
              if (sel_port == PORT_EXT) begin
                state_d = HOLD;
              end else if (sel_waits == '0) begin
                dsack_d = sel_port;
                state_d = FINISH;
              end else begin
                cnt_d   = sel_waits;
                port_d  = sel_port;
                state_d = WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (nAS) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - WAIT_W'(1);
            if (cnt_q == WAIT_W'(1)) begin
              dsack_d = port_q;
              state_d = FINISH;
            end
          end
        end
        FINISH, HOLD: begin
          if (nAS) begin
            dsack_d    = '0;
            conflict_d = 1'b0;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Boot overlay counts /AS rising edges at DRAM_CLK rate so none are missed.
  always_comb begin
    boot_d = boot_q;
    if (nAS && !nas_q && (boot_q != C_BOOT_END)) begin
      boot_d = boot_q + BOOT_W'(1);
    end
  end

  always_ff @(posedge DRAM_CLK or negedge nRST) begin
    if (!nRST) begin
      cpu_clk_q  <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      port_q     <= PORT_EXT;
      dsack_q    <= '0;
      conflict_q <= 1'b0;
      nas_q      <= 1'b1;
      boot_q     <= '0;
    end else begin
      cpu_clk_q  <= ~cpu_clk_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      port_q     <= port_d;
      dsack_q    <= dsack_d;
      conflict_q <= conflict_d;
      nas_q      <= nAS;
      boot_q     <= boot_d;
    end
  end

  bus_watchdog #(
    .BERR_CYCLES (BERR_CYCLES)
  ) u_watchdog (
    .DRAM_CLK  (DRAM_CLK),
    .nRST      (nRST),
    .tick_i    (tick),
    .nAS_i     (nAS),
    .timeout_o (timeout)
  );

  assign CPU_CLK = cpu_clk_q;
  assign DSACK   = dsack_q & {2{~nDS}};
  assign BERR    = timeout | conflict_q;
  assign BOOT    = (boot_q != C_BOOT_END);
  assign BUSY    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_cycle_ctl
// Description : Self-checking bench for bus_cycle_ctl against a tick-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_cycle_ctl;

  localparam int NCHAN       = 4;
  localparam int WAIT_W      = 4;
  localparam int BERR_CYCLES = 64;
  localparam int BOOT_CYCLES = 4;

  logic                    DRAM_CLK = 1'b0;
  logic                    nRST     = 1'b0;
  logic                    nAS      = 1'b1;
  logic                    nDS      = 1'b1;
  logic [NCHAN-1:0]        nSEL     = 4'hF;
  // ch3: 3 waits 32-bit, ch2: external, ch1: 0 waits 8-bit, ch0: 2 waits 16-bit
  logic [NCHAN*WAIT_W-1:0] CHAN_WAITS = {4'd3, 4'd5, 4'd0, 4'd2};
  logic [2*NCHAN-1:0]      CHAN_PORT  = {2'b11, 2'b00, 2'b01, 2'b10};
  wire                     CPU_CLK;
  wire  [1:0]              DSACK;
  wire                     BERR;
  wire                     BOOT;
  wire                     BUSY;

  bus_cycle_ctl #(
    .NCHAN       (NCHAN),
    .WAIT_W      (WAIT_W),
    .BERR_CYCLES (BERR_CYCLES),
    .BOOT_CYCLES (BOOT_CYCLES)
  ) dut (
    .DRAM_CLK   (DRAM_CLK),
    .nRST       (nRST),
    .nAS        (nAS),
    .nDS        (nDS),
    .nSEL       (nSEL),
    .CHAN_WAITS (CHAN_WAITS),
    .CHAN_PORT  (CHAN_PORT),
    .CPU_CLK    (CPU_CLK),
    .DSACK      (DSACK),
    .BERR       (BERR),
    .BOOT       (BOOT),
    .BUSY       (BUSY)
  );

  always #10 DRAM_CLK = ~DRAM_CLK;

  int   n_checks = 0;
  int   n_fail   = 0;

  // Model: bus cycle described by its start tick, channel properties and /AS history.
  bit         m_cpu, m_was_tick, m_active, m_conflict;
  int         m_tick, m_t0, m_wd, m_edges, m_waits;
  logic       m_as_prev;
  logic [1:0] m_port;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cpu = 0; m_active = 0; m_conflict = 0;
    m_tick = 0; m_t0 = 0; m_wd = 0; m_edges = 0; m_waits = 0;
    m_as_prev = 1'b1; m_port = 2'b00;
  endtask

  task automatic model_tick();
    m_tick++;
    if (nAS) m_wd = 0;
    else if (m_wd < BERR_CYCLES - 1) m_wd++;
    if (m_active) begin
      if (nAS) begin
        m_active   = 0;
        m_conflict = 0;
      end
    end else if (!nAS && nSEL != 4'hF) begin
      m_active   = 1;
      m_t0       = m_tick;
      m_conflict = ($countones(~nSEL) > 1);
      for (int i = 0; i < NCHAN; i++) begin
        if (!nSEL[i]) begin
          m_port  = CHAN_PORT[2*i +: 2];
          m_waits = int'(CHAN_WAITS[WAIT_W*i +: WAIT_W]);
        end
      end
    end
  endtask

  function automatic logic [1:0] exp_dsack_reg();
    if (m_active && !m_conflict && m_port != 2'b00 && (m_tick - m_t0) >= m_waits)
      return m_port;
    return 2'b00;
  endfunction

  // One DRAM_CLK: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge DRAM_CLK);
    m_was_tick = 0;
    if (!nRST) begin
      model_reset();
    end else begin
      if (nAS && !m_as_prev) m_edges++;
      m_as_prev  = nAS;
      m_was_tick = !m_cpu;
      m_cpu      = !m_cpu;
      if (m_was_tick) model_tick();
    end
    #1;
    chk("model CPU_CLK", 8'(CPU_CLK), 8'(m_cpu));
    chk("model DSACK", 8'(DSACK), 8'(exp_dsack_reg() & {2{~nDS}}));
    chk("model BERR", 8'(BERR), 8'((m_wd == BERR_CYCLES - 1) || m_conflict));
    chk("model BOOT", 8'(BOOT), 8'(m_edges < BOOT_CYCLES));
    chk("model BUSY", 8'(BUSY), 8'(m_active));
  endtask

  task automatic next_tick();
    step();
    if (!m_was_tick) step();
  endtask

  task automatic start_cycle(input logic [3:0] sel);
    nAS = 1'b0; nDS = 1'b0; nSEL = sel;
  endtask

  task automatic end_cycle();
    nAS = 1'b1; nDS = 1'b1; nSEL = 4'hF;
    next_tick();
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    chk("reset CPU_CLK", 8'(CPU_CLK), 8'h0);
    chk("reset DSACK", 8'(DSACK), 8'h0);
    chk("reset BERR", 8'(BERR), 8'h0);
    chk("reset BOOT", 8'(BOOT), 8'h1);
    chk("reset BUSY", 8'(BUSY), 8'h0);
    nRST = 1'b1;
    next_tick();

    // ch0: 2 waits, 16-bit
    start_cycle(4'b1110);
    next_tick();
    chk("ch0 T0 BUSY", 8'(BUSY), 8'h1);
    chk("ch0 T0 DSACK", 8'(DSACK), 8'h0);
    next_tick();
    chk("ch0 T0+1 DSACK", 8'(DSACK), 8'h0);
    next_tick();
    chk("ch0 T0+2 DSACK", 8'(DSACK), 8'h2);
    nDS = 1'b1;
    step();
    chk("ch0 DS release", 8'(DSACK), 8'h0);
    end_cycle();
    chk("ch0 idle BUSY", 8'(BUSY), 8'h0);

    // ch1: zero waits, 8-bit
    start_cycle(4'b1101);
    next_tick();
    chk("ch1 T0 DSACK", 8'(DSACK), 8'h1);
    end_cycle();

    // ch2: externally terminated, watchdog expiry
    start_cycle(4'b1011);
    for (int k = 1; k <= 70; k++) begin
      next_tick();
      if (k == 62) chk("ch2 tick62 BERR", 8'(BERR), 8'h0);
      if (k == 63) chk("ch2 tick63 BERR", 8'(BERR), 8'h1);
      if (k == 70) chk("ch2 tick70 DSACK", 8'(DSACK), 8'h0);
    end
    end_cycle();
    chk("ch2 BERR clear", 8'(BERR), 8'h0);
    chk("boot after 3", 8'(BOOT), 8'h1);

    // decode conflict
    start_cycle(4'b1100);
    next_tick();
    chk("conflict BERR", 8'(BERR), 8'h1);
    chk("conflict DSACK", 8'(DSACK), 8'h0);
    repeat (3) next_tick();
    end_cycle();
    chk("conflict BERR clear", 8'(BERR), 8'h0);
    chk("boot after 4", 8'(BOOT), 8'h0);

    // ch3 aborted mid-WAIT
    start_cycle(4'b0111);
    next_tick();
    next_tick();
    nAS = 1'b1; nDS = 1'b1; nSEL = 4'hF;
    next_tick();
    chk("abort BUSY", 8'(BUSY), 8'h0);
    chk("abort DSACK", 8'(DSACK), 8'h0);
    repeat (4) next_tick();
    chk("abort DSACK late", 8'(DSACK), 8'h0);
    chk("boot stays 0", 8'(BOOT), 8'h0);

    // select with /AS high is ignored
    nSEL = 4'b1110;
    next_tick();
    chk("sel nAS high BUSY", 8'(BUSY), 8'h0);
    nSEL = 4'hF;

    // ch3 full cycle: 3 waits, 32-bit
    start_cycle(4'b0111);
    repeat (4) next_tick();
    chk("ch3 T0+3 DSACK", 8'(DSACK), 8'h3);
    end_cycle();

    // asynchronous reset in WAIT
    start_cycle(4'b0111);
    next_tick();
    next_tick();
    nRST = 1'b0;
    #2;
    chk("async rst DSACK", 8'(DSACK), 8'h0);
    chk("async rst BUSY", 8'(BUSY), 8'h0);
    chk("async rst BOOT", 8'(BOOT), 8'h1);
    chk("async rst CPU_CLK", 8'(CPU_CLK), 8'h0);
    nAS = 1'b1; nDS = 1'b1; nSEL = 4'hF;
    repeat (2) step();
    nRST = 1'b1;
    next_tick();
    start_cycle(4'b1110);
    repeat (3) next_tick();
    chk("post-rst ch0 DSACK", 8'(DSACK), 8'h2);
    end_cycle();
    chk("post-rst BOOT", 8'(BOOT), 8'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
